// File: rtl/ram_dp_sync.sv
// Single-clock true-dual-port RAM with byte enables, post-reset clear sweep,
// 1- or 2-cycle read latency and collision report. Optional parity: RAM_DP_SYNC_PARITY_EN.
module ram_dp_sync #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 8192,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    output logic                                   init_done_o,
    input  logic                                   en_i_a,
    input  logic [DATA_WIDTH/8-1:0]                we_i_a,
    input  logic [$clog2(DEPTH*DATA_WIDTH/8)-1:0]  addr_i_a,
    input  logic [DATA_WIDTH-1:0]                  data_i_a,
    output logic                                   ready_o_a,
    output logic [DATA_WIDTH-1:0]                  data_o_a,
    output logic                                   valid_o_a,
    input  logic                                   en_i_b,
    input  logic [DATA_WIDTH/8-1:0]                we_i_b,
    input  logic [$clog2(DEPTH*DATA_WIDTH/8)-1:0]  addr_i_b,
    input  logic [DATA_WIDTH-1:0]                  data_i_b,
    output logic                                   ready_o_b,
    output logic [DATA_WIDTH-1:0]                  data_o_b,
    output logic                                   valid_o_b,
    output logic                                   collision_o
`ifdef RAM_DP_SYNC_PARITY_EN
   ,output logic                                   perr_o_a,
    output logic                                   perr_o_b
`endif
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int AW    = $clog2(DEPTH * BYTES);
    localparam int LSB   = $clog2(BYTES);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [IW-1:0]          r_cnt;
    logic                   w_ready, w_clr;

    logic [AW-1:0]          w_widx_a, w_widx_b;
    logic [IW-1:0]          w_idx_a, w_idx_b, w_wr_idx_a;
    logic                   w_inr_a, w_inr_b, w_acc_a, w_acc_b;
    logic [BYTES-1:0]       w_we_a, w_we_b;
    logic [DATA_WIDTH-1:0]  w_wd_a;
    logic [DATA_WIDTH-1:0]  w_old_a, w_old_b, w_mrg_a, w_mrg_b, w_rd_a, w_rd_b;

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]  r_q1_a, r_q1_b;
    logic                   r_v1_a, r_v1_b, r_coll;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_CLEAR;
        else       r_state <= w_state_nxt;
    end

    // NOTE: assign every always_comb output a default before any branch, otherwise a latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (CLEAR_ON_RESET == 0 || r_cnt == IW'(DEPTH - 1)) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      r_cnt <= '0;
        else if (w_clr) r_cnt <= r_cnt + 1'b1;
    end

    assign w_ready     = (r_state == S_RUN);
    assign w_clr       = (r_state == S_CLEAR) && (CLEAR_ON_RESET != 0);
    assign init_done_o = w_ready;
    assign ready_o_a   = w_ready;
    assign ready_o_b   = w_ready;

    // ---------------- address decode ----------------
    assign w_widx_a = addr_i_a >> LSB;
    assign w_widx_b = addr_i_b >> LSB;
    assign w_idx_a  = w_widx_a[IW-1:0];
    assign w_idx_b  = w_widx_b[IW-1:0];
    assign w_inr_a  = int'(w_widx_a) < DEPTH;
    assign w_inr_b  = int'(w_widx_b) < DEPTH;
    assign w_acc_a  = en_i_a && w_ready;
    assign w_acc_b  = en_i_b && w_ready;

    // The clear sweep borrows port a's write path.
    assign w_wr_idx_a = w_clr ? r_cnt : w_idx_a;
    assign w_wd_a     = w_clr ? '0 : data_i_a;
    assign w_we_a     = w_clr ? '1 : ((w_acc_a && w_inr_a) ? we_i_a : '0);
    assign w_we_b     = (w_acc_b && w_inr_b) ? we_i_b : '0;

    // ---------------- storage ----------------
`ifdef RAM_DP_SYNC_PARITY_EN
    logic [BYTES-1:0] r_par [DEPTH];
`endif

    // NOTE: the array has no reset; clearing it is the sweep's job, so it maps onto block RAM.
    // Port a is written last so it wins on lanes both ports enable.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < BYTES; i++) begin
            if (w_we_b[i]) begin
                r_mem[w_idx_b][8*i +: 8] <= data_i_b[8*i +: 8];
`ifdef RAM_DP_SYNC_PARITY_EN
                r_par[w_idx_b][i] <= ^data_i_b[8*i +: 8];
`endif
            end
            if (w_we_a[i]) begin
                r_mem[w_wr_idx_a][8*i +: 8] <= w_wd_a[8*i +: 8];
`ifdef RAM_DP_SYNC_PARITY_EN
                r_par[w_wr_idx_a][i] <= ^w_wd_a[8*i +: 8];
`endif
            end
        end
    end

    // ---------------- read path ----------------
    assign w_old_a = r_mem[w_idx_a];
    assign w_old_b = r_mem[w_idx_b];

    // NOTE: blocking assignments in combinational logic, non-blocking only for clocked state.
    always_comb begin
        w_mrg_a = w_old_a;
        w_mrg_b = w_old_b;
        for (int i = 0; i < BYTES; i++) begin
            if (we_i_a[i]) w_mrg_a[8*i +: 8] = data_i_a[8*i +: 8];
            if (we_i_b[i]) w_mrg_b[8*i +: 8] = data_i_b[8*i +: 8];
        end
    end

    assign w_rd_a = w_inr_a ? ((RDW_MODE != 0) ? w_mrg_a : w_old_a) : '0;
    assign w_rd_b = w_inr_b ? ((RDW_MODE != 0) ? w_mrg_b : w_old_b) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q1_a <= '0;
            r_q1_b <= '0;
            r_v1_a <= 1'b0;
            r_v1_b <= 1'b0;
            r_coll <= 1'b0;
        end else begin
            r_v1_a <= w_acc_a;
            r_v1_b <= w_acc_b;
            if (w_acc_a) r_q1_a <= w_rd_a;
            if (w_acc_b) r_q1_b <= w_rd_b;
            r_coll <= w_acc_a && w_acc_b && w_inr_a && w_inr_b &&
                      (w_widx_a == w_widx_b) && (|(we_i_a & we_i_b));
        end
    end

    assign collision_o = r_coll;

`ifdef RAM_DP_SYNC_PARITY_EN
    logic [BYTES-1:0] w_pst_a, w_pst_b, w_pcalc_a, w_pcalc_b;
    logic             w_perr_a, w_perr_b, r_pe1_a, r_pe1_b;

    // Stored parity follows the same read-during-write view as the data.
    always_comb begin
        w_pst_a = r_par[w_idx_a];
        w_pst_b = r_par[w_idx_b];
        for (int i = 0; i < BYTES; i++) begin
            if (RDW_MODE != 0 && we_i_a[i]) w_pst_a[i] = ^data_i_a[8*i +: 8];
            if (RDW_MODE != 0 && we_i_b[i]) w_pst_b[i] = ^data_i_b[8*i +: 8];
            w_pcalc_a[i] = ^w_rd_a[8*i +: 8];
            w_pcalc_b[i] = ^w_rd_b[8*i +: 8];
        end
    end

    assign w_perr_a = w_inr_a && (|(w_pst_a ^ w_pcalc_a));
    assign w_perr_b = w_inr_b && (|(w_pst_b ^ w_pcalc_b));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pe1_a <= 1'b0;
            r_pe1_b <= 1'b0;
        end else begin
            r_pe1_a <= w_acc_a && w_perr_a;
            r_pe1_b <= w_acc_b && w_perr_b;
        end
    end
`endif

    // ---------------- output stage ----------------
    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] r_q2_a, r_q2_b;
        logic                  r_v2_a, r_v2_b;
`ifdef RAM_DP_SYNC_PARITY_EN
        logic                  r_pe2_a, r_pe2_b;
`endif
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_q2_a <= '0;
                r_q2_b <= '0;
                r_v2_a <= 1'b0;
                r_v2_b <= 1'b0;
`ifdef RAM_DP_SYNC_PARITY_EN
                r_pe2_a <= 1'b0;
                r_pe2_b <= 1'b0;
`endif
            end else begin
                r_q2_a <= r_q1_a;
                r_q2_b <= r_q1_b;
                r_v2_a <= r_v1_a;
                r_v2_b <= r_v1_b;
`ifdef RAM_DP_SYNC_PARITY_EN
                r_pe2_a <= r_pe1_a;
                r_pe2_b <= r_pe1_b;
`endif
            end
        end
        assign data_o_a  = r_q2_a;
        assign data_o_b  = r_q2_b;
        assign valid_o_a = r_v2_a;
        assign valid_o_b = r_v2_b;
`ifdef RAM_DP_SYNC_PARITY_EN
        assign perr_o_a  = r_pe2_a;
        assign perr_o_b  = r_pe2_b;
`endif
    end else begin : g_lat1
        assign data_o_a  = r_q1_a;
        assign data_o_b  = r_q1_b;
        assign valid_o_a = r_v1_a;
        assign valid_o_b = r_v1_b;
`ifdef RAM_DP_SYNC_PARITY_EN
        assign perr_o_a  = r_pe1_a;
        assign perr_o_b  = r_pe1_b;
`endif
    end

endmodule

// File: tb/tb_ram_dp_sync.sv
// Randomised bench for ram_dp_sync: three configurations driven in lock-step and compared
// cycle by cycle against a word-array model with a due-cycle scoreboard.
module tb_ram_dp_sync;

    localparam int ND = 3;
    localparam int DEP [ND] = '{16, 16, 12};
    localparam int LAT [ND] = '{1, 2, 1};
    localparam int RDW [ND] = '{0, 1, 1};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        en_a, en_b;
    logic [3:0]  we_a, we_b;
    logic [5:0]  addr_a, addr_b;
    logic [31:0] din_a, din_b;

    logic [ND-1:0]        init_done, rdy_a, rdy_b, vld_a, vld_b, coll;
    logic [ND-1:0][31:0]  dout_a, dout_b;

    ram_dp_sync #(.DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .init_done_o(init_done[0]),
        .en_i_a(en_a), .we_i_a(we_a), .addr_i_a(addr_a), .data_i_a(din_a),
        .ready_o_a(rdy_a[0]), .data_o_a(dout_a[0]), .valid_o_a(vld_a[0]),
        .en_i_b(en_b), .we_i_b(we_b), .addr_i_b(addr_b), .data_i_b(din_b),
        .ready_o_b(rdy_b[0]), .data_o_b(dout_b[0]), .valid_o_b(vld_b[0]),
        .collision_o(coll[0]));

    ram_dp_sync #(.DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .init_done_o(init_done[1]),
        .en_i_a(en_a), .we_i_a(we_a), .addr_i_a(addr_a), .data_i_a(din_a),
        .ready_o_a(rdy_a[1]), .data_o_a(dout_a[1]), .valid_o_a(vld_a[1]),
        .en_i_b(en_b), .we_i_b(we_b), .addr_i_b(addr_b), .data_i_b(din_b),
        .ready_o_b(rdy_b[1]), .data_o_b(dout_b[1]), .valid_o_b(vld_b[1]),
        .collision_o(coll[1]));

    ram_dp_sync #(.DATA_WIDTH(32), .DEPTH(12), .READ_LATENCY(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .init_done_o(init_done[2]),
        .en_i_a(en_a), .we_i_a(we_a), .addr_i_a(addr_a), .data_i_a(din_a),
        .ready_o_a(rdy_a[2]), .data_o_a(dout_a[2]), .valid_o_a(vld_a[2]),
        .en_i_b(en_b), .we_i_b(we_b), .addr_i_b(addr_b), .data_i_b(din_b),
        .ready_o_b(rdy_b[2]), .data_o_b(dout_b[2]), .valid_o_b(vld_b[2]),
        .collision_o(coll[2]));

    // Reference state: word contents, expected read results keyed by due cycle, held data_o.
    logic [31:0] m    [ND][16];
    logic        pv   [ND][2][4];
    logic [31:0] pd   [ND][2][4];
    logic [31:0] hold [ND][2];
    logic        exp_coll [ND];
    int          n;
    int          n_tests, n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic flush();
        n = 0;
        for (int d = 0; d < ND; d++) begin
            exp_coll[d] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                hold[d][p] = '0;
                for (int s = 0; s < 4; s++) pv[d][p][s] = 1'b0;
            end
        end
    endtask

    // Applies the current inputs to the model for the coming clock edge.
    task automatic model_drive();
        int ia, ib, sa, sb;
        logic acc, a_ok, b_ok, inr_a, inr_b;
        logic [31:0] rd_a, rd_b;
        ia = int'(addr_a[5:2]);
        ib = int'(addr_b[5:2]);
        for (int d = 0; d < ND; d++) begin
            acc   = !rst && (n >= DEP[d]);
            a_ok  = acc && en_a;
            b_ok  = acc && en_b;
            inr_a = ia < DEP[d];
            inr_b = ib < DEP[d];
            rd_a  = '0;
            rd_b  = '0;
            if (inr_a) rd_a = (RDW[d] != 0) ? merge(m[d][ia], din_a, we_a) : m[d][ia];
            if (inr_b) rd_b = (RDW[d] != 0) ? merge(m[d][ib], din_b, we_b) : m[d][ib];
            sa = (n + LAT[d]) % 4;
            sb = sa;
            if (a_ok) begin pv[d][0][sa] = 1'b1; pd[d][0][sa] = rd_a; end
            if (b_ok) begin pv[d][1][sb] = 1'b1; pd[d][1][sb] = rd_b; end
            exp_coll[d] = a_ok && b_ok && inr_a && inr_b && (ia == ib) && ((we_a & we_b) != 4'b0);
            if (b_ok && inr_b) m[d][ib] = merge(m[d][ib], din_b, we_b);
            if (a_ok && inr_a) m[d][ia] = merge(m[d][ia], din_a, we_a);
        end
    endtask

    task automatic check_outputs();
        int s;
        logic ev_a, ev_b, rdy;
        s = n % 4;
        for (int d = 0; d < ND; d++) begin
            rdy  = !rst && (n >= DEP[d]);
            ev_a = pv[d][0][s];
            ev_b = pv[d][1][s];
            if (ev_a) begin hold[d][0] = pd[d][0][s]; pv[d][0][s] = 1'b0; end
            if (ev_b) begin hold[d][1] = pd[d][1][s]; pv[d][1][s] = 1'b0; end
            check($sformatf("d%0d init_done n=%0d", d, n), 32'(init_done[d]), 32'(rdy));
            check($sformatf("d%0d ready_a n=%0d", d, n), 32'(rdy_a[d]), 32'(rdy));
            check($sformatf("d%0d ready_b n=%0d", d, n), 32'(rdy_b[d]), 32'(rdy));
            check($sformatf("d%0d valid_a n=%0d", d, n), 32'(vld_a[d]), 32'(ev_a));
            check($sformatf("d%0d valid_b n=%0d", d, n), 32'(vld_b[d]), 32'(ev_b));
            check($sformatf("d%0d data_a n=%0d", d, n), dout_a[d], hold[d][0]);
            check($sformatf("d%0d data_b n=%0d", d, n), dout_b[d], hold[d][1]);
            check($sformatf("d%0d collision n=%0d", d, n), 32'(coll[d]), 32'(exp_coll[d]));
        end
    endtask

    task automatic tick();
        model_drive();
        @(posedge clk);
        if (!rst) n++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input logic ea, input logic [3:0] wa, input logic [5:0] aa, input logic [31:0] da,
                         input logic eb, input logic [3:0] wb, input logic [5:0] ab, input logic [31:0] db);
        en_a = ea; we_a = wa; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; addr_b = ab; din_b = db;
        tick();
    endtask

    task automatic idle(input int cycles);
        en_a = 1'b0;
        en_b = 1'b0;
        repeat (cycles) tick();
    endtask

    task automatic reset_on();
        rst = 1'b1;
        flush();
        #1;
        check_outputs();
    endtask

    // Once released, the sweep zeroes every word before any access can be accepted.
    task automatic reset_off();
        rst = 1'b0;
        for (int d = 0; d < ND; d++)
            for (int w = 0; w < 16; w++) m[d][w] = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        en_a = 1'b0; we_a = '0; addr_a = '0; din_a = '0;
        en_b = 1'b0; we_b = '0; addr_b = '0; din_b = '0;
        flush();
        @(negedge clk);
        check_outputs();
        repeat (2) tick();
        reset_off();
        idle(17);

        // Every word reads back zero after the sweep.
        for (int i = 0; i < 16; i++)
            drive(1'b1, 4'h0, 6'(i * 4), '0, 1'b1, 4'h0, 6'((15 - i) * 4), '0);
        idle(2);

        // Full write, then a single-lane update, read back on the other port.
        drive(1'b1, 4'hF, 6'h10, 32'hDEADBEEF, 1'b0, 4'h0, 6'h00, '0);
        drive(1'b1, 4'h1, 6'h10, 32'h000000AA, 1'b0, 4'h0, 6'h00, '0);
        drive(1'b0, 4'h0, 6'h00, '0, 1'b1, 4'h0, 6'h10, '0);
        idle(2);

        // Read-during-write on word 3.
        drive(1'b1, 4'hF, 6'h0C, 32'h11111111, 1'b0, 4'h0, 6'h00, '0);
        drive(1'b1, 4'hF, 6'h0E, 32'h22222222, 1'b0, 4'h0, 6'h00, '0);
        idle(2);

        // Overlapping and disjoint dual writes to word 8.
        drive(1'b1, 4'hF, 6'h20, 32'hAAAAAAAA, 1'b1, 4'hC, 6'h20, 32'hBBBBBBBB);
        drive(1'b0, 4'h0, 6'h00, '0, 1'b1, 4'h0, 6'h21, '0);
        drive(1'b1, 4'h3, 6'h20, 32'hAAAAAAAA, 1'b1, 4'hC, 6'h22, 32'hBBBBBBBB);
        drive(1'b1, 4'h0, 6'h20, '0, 1'b0, 4'h0, 6'h00, '0);
        idle(2);

        // Eight back-to-back reads on port b, including words beyond the 12-word instance.
        for (int i = 0; i < 8; i++)
            drive(1'b0, 4'h0, 6'h00, '0, 1'b1, 4'h0, 6'(i * 8 + 1), '0);
        idle(3);

        // Reset while a read is in flight.
        drive(1'b1, 4'h0, 6'h10, '0, 1'b1, 4'h0, 6'h10, '0);
        reset_on();
        idle(3);
        reset_off();
        idle(17);

        // Random traffic; half of the addresses land on word 8 to provoke collisions.
        for (int k = 0; k < 400; k++) begin
            logic [5:0] aa, ab;
            aa = ($urandom % 2 == 0) ? 6'($urandom % 64) : 6'(32 + $urandom % 4);
            ab = ($urandom % 2 == 0) ? 6'($urandom % 64) : 6'(32 + $urandom % 4);
            drive(($urandom % 4) != 0, ($urandom % 2 == 0) ? 4'($urandom) : 4'h0, aa, $urandom,
                  ($urandom % 4) != 0, ($urandom % 2 == 0) ? 4'($urandom) : 4'h0, ab, $urandom);
        end
        idle(3);

        // Reset five cycles into the sweep restarts it from word 0.
        reset_on();
        idle(2);
        reset_off();
        idle(5);
        reset_on();
        idle(2);
        reset_off();
        idle(17);
        for (int i = 0; i < 16; i++)
            drive(1'b1, 4'h0, 6'(i * 4 + 2), '0, 1'b1, 4'h0, 6'((15 - i) * 4 + 3), '0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
